// File: rtl/temporal_equal_n.sv
// temporal_equal_n -- N-input race-logic EQUAL for the pulse-width temporal domain.
//
// A value on each input is the aclk cycle of its first rising edge inside a gamma
// cycle (grst marks the gamma-cycle start). y pulses when every enabled input has
// arrived within TOL cycles of the earliest arrival.
//
// Ports:
//   aclk      in   1     clock, all state on posedge
//   grst      in   1     synchronous active-high reset / gamma-cycle start
//   en_mask   in   N_IN  channel enables, latched while grst=1
//   a         in   N_IN  pulse-width-coded input spikes
//   y         out  1     equality pulse (one cycle after the completing edge)
//   y_time    out  TW    cnt value of the completing arrival, valid with match
//   match     out  1     sticky: equality fired this gamma cycle
//   mismatch  out  1     sticky: spread exceeded TOL or window closed incomplete

// Per-channel edge detector: registers the previous input level and remembers
// whether this channel has already produced its (single) arrival.
module temporal_equal_lane (
    input  logic aclk,
    input  logic grst,
    input  logic a,
    input  logic en,
    input  logic win_open,
    output logic rise,
    output logic arrived
);
    logic a_q;

    // a_q clears on reset, so a level already high after grst counts as an edge.
    assign rise = a & ~a_q & en & ~arrived & win_open;

    always_ff @(posedge aclk) begin
        if (grst) begin
            a_q     <= 1'b0;
            arrived <= 1'b0;
        end else begin
            a_q     <= a;
            arrived <= arrived | rise;
        end
    end
endmodule

module temporal_equal_n #(
    parameter  int N_IN              = 4,
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int TOL               = 0,
    localparam int TW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1
) (
    input  logic            aclk,
    input  logic            grst,
    input  logic [N_IN-1:0] en_mask,
    input  logic [N_IN-1:0] a,
    output logic            y,
    output logic [TW-1:0]   y_time,
    output logic            match,
    output logic            mismatch
);
    localparam logic [TW-1:0] CNT_MAX = TW'(GAMMA_CYCLE_WIDTH - 1);
    // Spread can never exceed CNT_MAX, so clamping keeps the compare in TW bits
    // without changing its outcome.
    localparam logic [TW-1:0] TOL_T =
        TW'((TOL > GAMMA_CYCLE_WIDTH - 1) ? GAMMA_CYCLE_WIDTH - 1 : TOL);

    logic [TW-1:0]   cnt;
    logic [TW-1:0]   first_t;
    logic [N_IN-1:0] mask_q;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] arrived;
    logic            closed;
    logic [N_IN-1:0] seen;
    logic [TW-1:0]   ft_eff;
    logic [TW-1:0]   spread;
    logic            complete;
    logic            any_arr;

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        temporal_equal_lane u_lane (
            .aclk     (aclk),
            .grst     (grst),
            .a        (a[i]),
            .en       (mask_q[i]),
            .win_open (~closed),
            .rise     (rise[i]),
            .arrived  (arrived[i])
        );
    end

    always_comb begin
        closed   = (cnt == CNT_MAX);
        seen     = arrived | rise;
        any_arr  = |seen;
        // On the very first arrival cycle first_t is not loaded yet; use cnt.
        ft_eff   = (arrived == '0) ? cnt : first_t;
        spread   = cnt - ft_eff;
        // An all-zero mask never completes: nothing can arrive.
        complete = (mask_q != '0) && ((seen & mask_q) == mask_q);
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            cnt      <= '0;
            first_t  <= '0;
            y        <= 1'b0;
            y_time   <= '0;
            match    <= 1'b0;
            mismatch <= 1'b0;
            mask_q   <= en_mask;
        end else begin
            if (!closed)
                cnt <= cnt + 1'b1;
            if (arrived == '0 && rise != '0)
                first_t <= cnt;
            if (!match && !mismatch) begin
                if (complete && spread <= TOL_T) begin
                    match  <= 1'b1;
                    y_time <= cnt;
                    y      <= 1'b1;
                end else if (any_arr && spread > TOL_T) begin
                    mismatch <= 1'b1;
                end else if (closed) begin
                    mismatch <= 1'b1;
                end
            end else if (y && (((a & mask_q) != mask_q) || closed)) begin
                // y only drops here; match stays set, so it cannot re-rise.
                y <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_temporal_equal_n.sv
module tb_temporal_equal_n;
    localparam int N  = 4;
    localparam int G  = 16;
    localparam int TW = 4;

    logic         aclk;
    logic         grst;
    logic [N-1:0] en_mask;
    logic [N-1:0] a;
    logic         y0, y2, m0, m2, mm0, mm2;
    logic [TW-1:0] t0, t2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: mask latched at last grst and every input vector sampled since.
    logic [N-1:0] mask_m;
    logic [N-1:0] hist[$];

    // Pulse description for the current gamma run (two pulses per channel).
    int st[N], st2[N], wd[N];

    temporal_equal_n #(.N_IN(N), .GAMMA_CYCLE_WIDTH(G), .TOL(0)) u_t0 (
        .aclk(aclk), .grst(grst), .en_mask(en_mask), .a(a),
        .y(y0), .y_time(t0), .match(m0), .mismatch(mm0));

    temporal_equal_n #(.N_IN(N), .GAMMA_CYCLE_WIDTH(G), .TOL(2)) u_t2 (
        .aclk(aclk), .grst(grst), .en_mask(en_mask), .a(a),
        .y(y2), .y_time(t2), .match(m2), .mismatch(mm2));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Arrival-time view of the gamma cycle: find each channel's first edge, then
    // scan the timeline for the decision point and for the end of the y pulse.
    function automatic void model(input int tol, output logic ey, output logic [TW-1:0] et,
                                  output logic em, output logic emm);
        int arr[N];
        int first, c_m, c_mm, j_fall, cnt;
        logic [N-1:0] prev;
        bit all_in;
        for (int i = 0; i < N; i++) arr[i] = -1;
        first = -1; c_m = -1; c_mm = -1; j_fall = -1;
        et = '0;
        for (int k = 0; k < hist.size(); k++) begin
            cnt  = (k < G-1) ? k : G-1;
            prev = (k == 0) ? '0 : hist[k-1];
            for (int i = 0; i < N; i++)
                if (mask_m[i] && arr[i] < 0 && hist[k][i] && !prev[i] && cnt < G-1) begin
                    arr[i] = cnt;
                    if (first < 0) first = cnt;
                end
            if (c_m < 0 && c_mm < 0) begin
                all_in = (mask_m != '0);
                for (int i = 0; i < N; i++) if (mask_m[i] && arr[i] < 0) all_in = 0;
                if (all_in && cnt - first <= tol) begin
                    c_m = k; et = TW'(cnt);
                end else if (first >= 0 && cnt - first > tol) c_mm = k;
                else if (cnt == G-1) c_mm = k;
            end else if (c_m >= 0 && j_fall < 0 && k > c_m) begin
                if ((hist[k] & mask_m) != mask_m || cnt == G-1) j_fall = k;
            end
        end
        em  = (c_m >= 0);
        emm = (c_mm >= 0);
        ey  = (c_m >= 0) && (j_fall < 0);
    endfunction

    task automatic check_all();
        logic ey, em, emm;
        logic [TW-1:0] et;
        model(0, ey, et, em, emm);
        chk("tol0_y", y0, ey);  chk("tol0_match", m0, em);
        chk("tol0_mismatch", mm0, emm); chk("tol0_ytime", t0, et);
        chk("tol0_excl", m0 & mm0, 0);
        model(2, ey, et, em, emm);
        chk("tol2_y", y2, ey);  chk("tol2_match", m2, em);
        chk("tol2_mismatch", mm2, emm); chk("tol2_ytime", t2, et);
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] m, input logic [N-1:0] av);
        grst = r; en_mask = m; a = av;
        @(posedge aclk); #1;
        if (r) begin
            hist.delete();
            mask_m = m;
        end else hist.push_back(av);
        check_all();
    endtask

    function automatic logic [N-1:0] pat(input int k);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = (k >= st[i] && k < st[i] + wd[i]) || (k >= st2[i] && k < st2[i] + wd[i]);
        return v;
    endfunction

    // One grst cycle (with garbage on a, which must be ignored) then len samples.
    task automatic run(input logic [N-1:0] m, input int len);
        cyc(1'b1, m, N'($urandom));
        for (int k = 0; k < len; k++) cyc(1'b0, m, pat(k));
    endtask

    task automatic set_ch(input int i, input int s, input int w, input int s2);
        st[i] = s; wd[i] = w; st2[i] = s2;
    endtask

    initial begin
        grst = 1'b1; en_mask = '1; a = '0;
        for (int i = 0; i < N; i++) set_ch(i, -100, 0, -100);

        // 1: no inputs
        run(4'hF, 20);
        chk("c1_mismatch", mm0, 1); chk("c1_match", m0, 0);

        // 2: all rise at 2, fall at 10
        for (int i = 0; i < N; i++) set_ch(i, 2, 8, -100);
        run(4'hF, 20);
        chk("c2_match", m0, 1); chk("c2_ytime", t0, 2);

        // 3/4: a3 two cycles late
        set_ch(3, 4, 8, -100);
        run(4'hF, 20);
        chk("c3_mismatch", mm0, 1); chk("c4_match", m2, 1); chk("c4_ytime", t2, 4);

        // 5: mask 0011, a0 re-pulses later
        for (int i = 0; i < N; i++) set_ch(i, -100, 0, -100);
        set_ch(0, 5, 3, 10); set_ch(1, 5, 3, -100);
        run(4'b0011, 20);
        chk("c5_match", m0, 1); chk("c5_ytime", t0, 5);

        // 6: grst lands at cnt=6 while y is high, then a clean case 2
        for (int i = 0; i < N; i++) set_ch(i, 2, 8, -100);
        run(4'hF, 6);
        chk("c6_y_before", y0, 1);
        cyc(1'b1, 4'hF, 4'hF);
        chk("c6_y_after", y0, 0); chk("c6_match_after", m0, 0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 4'hF, pat(k));
        chk("c6_match", m0, 1); chk("c6_ytime", t0, 2);

        // Randomized gamma cycles
        for (int r = 0; r < 60; r++) begin
            logic [N-1:0] m;
            int base;
            m    = ($urandom_range(0, 1) == 0) ? 4'hF : N'($urandom);
            base = $urandom_range(0, 14);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0)
                    set_ch(i, base + $urandom_range(0, 3), $urandom_range(1, 10),
                           $urandom_range(0, 25));
                else
                    set_ch(i, $urandom_range(0, 20), $urandom_range(1, 10),
                           ($urandom_range(0, 1) != 0) ? -100 : $urandom_range(0, 25));
            end
            run(m, $urandom_range(3, 22));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
